ysyx_core_ctrl: RTL and testbench
=================================

YSYX_CORE_CTRL -- requirements
Module: ysyx_core_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 255, max wait cycles for a fetch or memory response before fault.
REQ-002 SHALL provide parameter CNT_W, default 32, width of the retire counter.
REQ-003 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ifu_rvalid  input  1  instruction memory response valid.
REQ-006 SHALL have dec_is_load, dec_is_store, dec_rf_wr_en, dec_do_jump, dec_is_ebreak  input  1 each  decoder flags for the latched instruction.
REQ-007 SHALL have lsu_done  input  1  data access complete.
REQ-008 SHALL have ifu_req, inst_latch_en, lsu_req, lsu_wen, rf_wr_en, pc_wr_en, pc_sel_jump, retire  output  1 each  datapath control strobes.
REQ-009 SHALL have halt, fault  output  1 each  sticky stop indication and timeout cause.
REQ-010 SHALL have state  output  3  current FSM state encoding, for trace.

Function
REQ-011 SHALL implement FSM states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-012 SHALL move IDLE->FETCH unconditionally after one cycle.
REQ-013 SHALL assert ifu_req throughout FETCH; on ifu_rvalid=1 in FETCH, assert inst_latch_en combinationally that cycle and move to DECODE.
REQ-014 SHALL ignore ifu_rvalid and lsu_done in every state other than FETCH and MEM respectively.
REQ-015 SHALL spend exactly one cycle in DECODE; dec_is_ebreak=1 -> HALT with fault=0, else -> EXEC.
REQ-016 SHALL spend exactly one cycle in EXEC; dec_is_load|dec_is_store -> MEM, else -> WB.
REQ-017 SHALL assert lsu_req throughout MEM with lsu_wen=dec_is_store; on lsu_done=1 move to WB.
REQ-018 SHALL in WB (one cycle) drive rf_wr_en=dec_rf_wr_en, pc_wr_en=1, pc_sel_jump=dec_do_jump, retire=1, then -> FETCH.
REQ-019 SHALL deassert all strobes outside the states named above; no strobe held beyond its state.
REQ-020 SHALL clear an 8-bit-min wait counter on entry to FETCH/MEM and increment it each waiting cycle; reaching TIMEOUT_CYC without response -> HALT with fault=1.
REQ-021 SHALL give the response priority when it arrives in the same cycle the counter reaches TIMEOUT_CYC.
REQ-022 SHALL hold halt=1 in HALT, all strobes 0, until rst; fault sticky likewise.
REQ-023 SHALL yield minimum latency fetch-response to retire of 3 cycles (non-memory) and 4 + LSU wait (memory).

Reset
REQ-024 SHALL on rst=1 at a clock edge enter IDLE, clear wait counter, halt, fault, retire counter; all outputs 0 next cycle.
REQ-025 SHALL abort any in-flight FETCH/MEM on reset with no retire; rst overrides every transition.

Configuration
REQ-026 SHALL with macro YSYX_CORE_CTRL_PERF_EN defined add output retire_cnt [CNT_W-1:0], incremented on each retire, wrapping from all-ones to 0, cleared by reset.
REQ-027 SHALL without YSYX_CORE_CTRL_PERF_EN omit retire_cnt port and counter entirely; all other behaviour identical.

Structure
REQ-028 SHALL place state encodings and default TIMEOUT_CYC in shared package ysyx_ctrl_pkg.
REQ-029 SHALL implement the wait counter as sub-module ysyx_wait_timer (clear, enable, expired outputs).

Verification
REQ-030 SHALL verify ALU op: reset, ifu_rvalid at cycle 3 with dec_rf_wr_en=1 -> DECODE, EXEC, WB; retire and rf_wr_en=1 exactly in cycle 6.
REQ-031 SHALL verify store: dec_is_store=1, lsu_done after 5 cycles -> lsu_req high 6 cycles, lsu_wen=1, rf_wr_en=0 in WB.
REQ-032 SHALL verify ebreak: dec_is_ebreak=1 -> HALT after DECODE, halt=1, fault=0, no retire, ifu_req stays 0 for 20 cycles.
REQ-033 SHALL verify timeout: TIMEOUT_CYC=4, no ifu_rvalid -> HALT with fault=1 after 4 FETCH cycles; rvalid in 4th cycle -> DECODE instead.
REQ-034 SHALL verify reset mid-MEM: rst during lsu_req -> next cycle state=0, lsu_req=0, retire_cnt unchanged-then-cleared to 0.
REQ-035 SHALL verify PERF_EN: CNT_W=4, 17 jump instructions -> retire_cnt=1, pc_sel_jump=1 in every WB.

Source files
------------

// File: rtl/ysyx_ctrl_pkg.sv
// ysyx_ctrl_pkg: shared FSM state encodings, default timeout and wait-counter width helper
package ysyx_ctrl_pkg;
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;
   localparam int TIMEOUT_CYC_DEF = 255;
   function automatic int wait_w(input int lim);
      return (lim > 255) ? $clog2(lim + 1) : 8;
   endfunction
endpackage

// File: rtl/ysyx_wait_timer.sv
// ysyx_wait_timer: response wait counter, flags the LIMIT-th consecutive waiting cycle
module ysyx_wait_timer
   import ysyx_ctrl_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_CYC_DEF,
   parameter int W     = wait_w(LIMIT)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [W-1:0] cnt;
   assign expired = enable && (cnt == W'(LIMIT - 1));
   // count waiting cycles; cleared whenever the controller is not waiting
   always_ff @(posedge clk) begin
      if (rst || clear) cnt <= '0;
      else if (enable) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/ysyx_core_ctrl.sv
// ysyx_core_ctrl: multi-cycle core control FSM; YSYX_CORE_CTRL_PERF_EN adds the retire_cnt output
module ysyx_core_ctrl
   import ysyx_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ifu_rvalid,
   input  logic             dec_is_load,
   input  logic             dec_is_store,
   input  logic             dec_rf_wr_en,
   input  logic             dec_do_jump,
   input  logic             dec_is_ebreak,
   input  logic             lsu_done,
   output logic             ifu_req,
   output logic             inst_latch_en,
   output logic             lsu_req,
   output logic             lsu_wen,
   output logic             rf_wr_en,
   output logic             pc_wr_en,
   output logic             pc_sel_jump,
   output logic             retire,
   output logic             halt,
   output logic             fault,
`ifdef YSYX_CORE_CTRL_PERF_EN
   output logic [CNT_W-1:0] retire_cnt,
`endif
   output logic [2:0]       state
);
   state_t state_q, state_d;
   logic   fault_q, expired, waiting, wait_en;
   assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
   assign wait_en = ((state_q == S_FETCH) && !ifu_rvalid) || ((state_q == S_MEM) && !lsu_done);
   assign state   = state_q;
   assign fault   = fault_q;
   ysyx_wait_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (!waiting),
      .enable (wait_en),
      .expired(expired)
   );
   // state register and sticky timeout cause
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_q | expired;
      end
   end
   // next state and per-state strobes; a response wins over a coincident timeout
   always_comb begin
      state_d       = state_q;
      ifu_req       = 1'b0;
      inst_latch_en = 1'b0;
      lsu_req       = 1'b0;
      lsu_wen       = 1'b0;
      rf_wr_en      = 1'b0;
      pc_wr_en      = 1'b0;
      pc_sel_jump   = 1'b0;
      retire        = 1'b0;
      halt          = 1'b0;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH: begin
            ifu_req       = 1'b1;
            inst_latch_en = ifu_rvalid;
            state_d       = ifu_rvalid ? S_DECODE : (expired ? S_HALT : S_FETCH);
         end
         S_DECODE: state_d = dec_is_ebreak ? S_HALT : S_EXEC;
         S_EXEC:   state_d = (dec_is_load || dec_is_store) ? S_MEM : S_WB;
         S_MEM: begin
            lsu_req = 1'b1;
            lsu_wen = dec_is_store;
            state_d = lsu_done ? S_WB : (expired ? S_HALT : S_MEM);
         end
         S_WB: begin
            rf_wr_en    = dec_rf_wr_en;
            pc_wr_en    = 1'b1;
            pc_sel_jump = dec_do_jump;
            retire      = 1'b1;
            state_d     = S_FETCH;
         end
         S_HALT:   halt = 1'b1;
         default:  state_d = S_IDLE;
      endcase
   end
`ifdef YSYX_CORE_CTRL_PERF_EN
   // retired-instruction counter, wraps naturally
   always_ff @(posedge clk) begin
      if (rst) retire_cnt <= '0;
      else if (retire) retire_cnt <= retire_cnt + 1'b1;
   end
`else
   localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_ysyx_core_ctrl.sv
// tb_ysyx_core_ctrl: per-cycle vector table built from an instruction-level model, applied to two DUTs
module tb_ysyx_core_ctrl;
   logic clk = 1'b0, rst = 1'b0, ifu_rvalid = 1'b0, lsu_done = 1'b0;
   logic dec_is_load = 1'b0, dec_is_store = 1'b0, dec_rf_wr_en = 1'b0, dec_do_jump = 1'b0, dec_is_ebreak = 1'b0;
   logic ifu_req_a, inst_latch_en_a, lsu_req_a, lsu_wen_a, rf_wr_en_a, pc_wr_en_a, pc_sel_jump_a, retire_a, halt_a, fault_a;
   logic ifu_req_b, inst_latch_en_b, lsu_req_b, lsu_wen_b, rf_wr_en_b, pc_wr_en_b, pc_sel_jump_b, retire_b, halt_b, fault_b;
   logic [2:0] state_a, state_b;
   logic [3:0] retire_cnt_a, retire_cnt_b;
   logic [12:0] out_a, out_b, got;
   logic [3:0] got_rc;
   always #5 clk = ~clk;
   ysyx_core_ctrl #(.TIMEOUT_CYC(255), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .ifu_rvalid(ifu_rvalid), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
      .dec_rf_wr_en(dec_rf_wr_en), .dec_do_jump(dec_do_jump), .dec_is_ebreak(dec_is_ebreak), .lsu_done(lsu_done),
      .ifu_req(ifu_req_a), .inst_latch_en(inst_latch_en_a), .lsu_req(lsu_req_a), .lsu_wen(lsu_wen_a),
      .rf_wr_en(rf_wr_en_a), .pc_wr_en(pc_wr_en_a), .pc_sel_jump(pc_sel_jump_a), .retire(retire_a),
      .halt(halt_a), .fault(fault_a),
`ifdef YSYX_CORE_CTRL_PERF_EN
      .retire_cnt(retire_cnt_a),
`endif
      .state(state_a)
   );
   ysyx_core_ctrl #(.TIMEOUT_CYC(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .ifu_rvalid(ifu_rvalid), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
      .dec_rf_wr_en(dec_rf_wr_en), .dec_do_jump(dec_do_jump), .dec_is_ebreak(dec_is_ebreak), .lsu_done(lsu_done),
      .ifu_req(ifu_req_b), .inst_latch_en(inst_latch_en_b), .lsu_req(lsu_req_b), .lsu_wen(lsu_wen_b),
      .rf_wr_en(rf_wr_en_b), .pc_wr_en(pc_wr_en_b), .pc_sel_jump(pc_sel_jump_b), .retire(retire_b),
      .halt(halt_b), .fault(fault_b),
`ifdef YSYX_CORE_CTRL_PERF_EN
      .retire_cnt(retire_cnt_b),
`endif
      .state(state_b)
   );
`ifndef YSYX_CORE_CTRL_PERF_EN
   assign retire_cnt_a = '0;
   assign retire_cnt_b = '0;
`endif
   assign out_a = {state_a, ifu_req_a, inst_latch_en_a, lsu_req_a, lsu_wen_a, rf_wr_en_a, pc_wr_en_a, pc_sel_jump_a, retire_a, halt_a, fault_a};
   assign out_b = {state_b, ifu_req_b, inst_latch_en_b, lsu_req_b, lsu_wen_b, rf_wr_en_b, pc_wr_en_b, pc_sel_jump_b, retire_b, halt_b, fault_b};

   // one record per clock cycle: inputs to drive and outputs the model requires
   // dec = {load, store, rf_wr, jump, ebreak}
   // exp = {state, ifu_req, latch, lsu_req, lsu_wen, rf_wr, pc_wr, jump, retire, halt, fault}
   typedef struct {
      bit          rst, rv, done, chk, b;
      logic [4:0]  dec;
      logic [12:0] exp;
      logic [3:0]  rc;
      string       tag;
   } vec_t;
   vec_t q[$];
   int   checks = 0, failures = 0, rc = 0;
   bit   flt = 1'b0, halted = 1'b0;

   function automatic logic [12:0] ex(input int st, input logic [9:0] s);
      return {3'(st), s};
   endfunction

   task automatic push(input bit r, input bit rv, input bit dn, input bit ch, input bit b,
                       input logic [4:0] dec, input logic [12:0] e, input string tag);
      vec_t v;
      v.rst = r; v.rv = rv; v.done = dn; v.chk = ch; v.b = b;
      v.dec = dec; v.exp = e; v.rc = 4'(rc); v.tag = tag;
      q.push_back(v);
   endtask

   task automatic add_reset(input bit b);
      push(1'b1, 1'($urandom), 1'($urandom), 1'b0, b, 5'($urandom), '0, "reset");
      rc = 0; flt = 1'b0; halted = 1'b0;
      push(1'b0, 1'($urandom), 1'($urandom), 1'b1, b, 5'($urandom), ex(0, 10'b0), "idle");
   endtask

   task automatic add_halt(input bit b, input int n);
      for (int i = 0; i < n; i++)
         push(1'b0, 1'($urandom), 1'($urandom), 1'b1, b, 5'($urandom), ex(6, {8'b0, 1'b1, flt}), "halt");
   endtask

   // one instruction: fetch wait df cycles, optional memory wait dl cycles, lim = timeout,
   // cut >= 0 stops the trace after that many memory cycles (reset follows)
   task automatic add_inst(input bit b, input int lim, input int df, input logic [4:0] dec,
                           input int dl, input int cut, input string tag);
      for (int i = 0; i <= df; i++) begin
         bit r = (i == df);
         push(1'b0, r, 1'($urandom), 1'b1, b, 5'($urandom), ex(1, {1'b1, r, 8'b0}), {tag, "_fetch"});
         if (!r && i == lim - 1) begin halted = 1'b1; flt = 1'b1; return; end
      end
      push(1'b0, 1'($urandom), 1'($urandom), 1'b1, b, dec, ex(2, 10'b0), {tag, "_decode"});
      if (dec[0]) begin halted = 1'b1; flt = 1'b0; return; end
      push(1'b0, 1'($urandom), 1'($urandom), 1'b1, b, dec, ex(3, 10'b0), {tag, "_exec"});
      if (dec[4] || dec[3])
         for (int i = 0; i <= dl; i++) begin
            bit r = (i == dl);
            if (i == cut) return;
            push(1'b0, 1'($urandom), r, 1'b1, b, dec, ex(4, {2'b00, 1'b1, dec[3], 6'b0}), {tag, "_mem"});
            if (!r && i == lim - 1) begin halted = 1'b1; flt = 1'b1; return; end
         end
      push(1'b0, 1'($urandom), 1'($urandom), 1'b1, b, dec, ex(5, {4'b0, dec[2], 1'b1, dec[1], 1'b1, 2'b00}), {tag, "_wb"});
      rc++;
   endtask

   initial begin
      add_reset(0);
      add_inst(0, 255, 1, 5'b00100, 0, -1, "alu");
      add_inst(0, 255, 0, 5'b01000, 5, -1, "store");
      add_inst(0, 255, 2, 5'b10110, 1, -1, "load_jmp");
      add_inst(0, 255, 0, 5'b00101, 0, -1, "ebreak");
      add_halt(0, 20);
      add_reset(1);
      add_inst(1, 4, 99, 5'b00100, 0, -1, "fetch_to");
      add_halt(1, 5);
      add_reset(1);
      add_inst(1, 4, 3, 5'b00100, 0, -1, "fetch_late");
      add_inst(1, 4, 0, 5'b10100, 3, -1, "mem_late");
      add_inst(1, 4, 0, 5'b01000, 99, -1, "mem_to");
      add_halt(1, 3);
      add_reset(0);
      add_inst(0, 255, 0, 5'b00100, 0, -1, "pre");
      add_inst(0, 255, 0, 5'b01000, 9, 3, "mem_abort");
      add_reset(0);
      add_inst(0, 255, 0, 5'b00100, 0, -1, "post_abort");
      add_reset(0);
      for (int i = 0; i < 17; i++)
         add_inst(0, 255, $urandom_range(0, 2), {2'b00, 1'($urandom), 2'b10}, 0, -1, "jump");
      add_inst(0, 255, 2, 5'b00100, 0, -1, "post_jump");
      add_reset(0);
      for (int i = 0; i < 150; i++) begin
         if (halted) begin add_halt(0, 2); add_reset(0); end
         add_inst(0, 255, $urandom_range(0, 5), {4'($urandom), ($urandom_range(0, 29) == 0)},
                  $urandom_range(0, 5), -1, "rand");
      end
      foreach (q[k]) begin
         @(negedge clk);
         rst = q[k].rst; ifu_rvalid = q[k].rv; lsu_done = q[k].done;
         {dec_is_load, dec_is_store, dec_rf_wr_en, dec_do_jump, dec_is_ebreak} = q[k].dec;
         #1;
         if (q[k].chk) begin
            got = q[k].b ? out_b : out_a;
            got_rc = q[k].b ? retire_cnt_b : retire_cnt_a;
            checks++;
            if (got !== q[k].exp) begin
               failures++;
               $display("FAIL %s vec=%0d got=%b exp=%b (state,ifu,latch,lsu,wen,rf,pcw,jmp,ret,halt,fault)",
                        q[k].tag, k, got, q[k].exp);
            end
`ifdef YSYX_CORE_CTRL_PERF_EN
            checks++;
            if (got_rc !== q[k].rc) begin
               failures++;
               $display("FAIL %s_retire_cnt vec=%0d got=%0d exp=%0d", q[k].tag, k, got_rc, q[k].rc);
            end
`endif
         end
      end
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
